// File: rtl/nsys_fir_preadd.sv
// nsys_fir_preadd: systolic symmetric pre-add FIR with double-buffered coefficients and convergent rounding
module nsys_fir_preadd #(
    parameter int    NTAPS     = 5,
    parameter int    NBITS     = 12,
    parameter int    OUT_SHIFT = 16,
    parameter int    SCALE_ADD = 0,
    parameter string SATURATE  = "TRUE",
    parameter string CASCADE   = "FALSE"
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           ce_i,
    input  logic signed [NBITS-1:0]        dat_i,
    input  logic signed [NBITS-1:0]        preadd_i,
    input  logic signed [NBITS-1:0]        add_i,
    input  logic                           coeff_wr_i,
    input  logic [$clog2(NTAPS)-1:0]       coeff_addr_i,
    input  logic signed [17:0]             coeff_dat_i,
    input  logic                           coeff_commit_i,
    input  logic signed [47:0]             pc_i,
    output logic signed [NBITS:0]          dat_o,
    output logic                           valid_o,
    output logic                           sat_o,
    output logic                           coeff_err_o,
    output logic signed [47:0]             pc_o
);
    localparam int AW  = $clog2(NTAPS);
    localparam int LAT = NTAPS + 3;
    localparam int CW  = $clog2(LAT + 1);
    localparam int XW  = NBITS + 1;
    localparam int NX  = 2 * NTAPS - 1;
    localparam bit SAT = (SATURATE == "TRUE");
    localparam bit CAS = (CASCADE == "TRUE");
    localparam logic [47:0]        MASK = (48'd1 << OUT_SHIFT) - 48'd1;
    localparam logic [47:0]        HALF = (48'd1 << OUT_SHIFT) >> 1;
    localparam logic signed [47:0] MAXV = (48'sd1 <<< NBITS) - 48'sd1;
    localparam logic signed [47:0] MINV = -(48'sd1 <<< NBITS);
    typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;
    state_t                  state, state_nxt;
    logic [CW-1:0]           cnt, cnt_nxt;
    logic signed [17:0]      shadow [NTAPS];
    logic signed [17:0]      active [NTAPS];
    logic                    pend;
    logic signed [XW-1:0]    xs [NX];
    logic signed [NBITS-1:0] a_d [2];
    logic signed [47:0]      mr [NTAPS];
    logic signed [47:0]      acc [NTAPS];
    logic signed [47:0]      s, q, r;
    logic [47:0]             frac;
    logic                    up, hi, lo, sat_c;
    logic [XW-1:0]           y_c;
    // shadow writes and commit latch run regardless of ce; the bank swap waits for a ce cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow      <= '{default: '0};
            active      <= '{default: '0};
            pend        <= 1'b0;
            coeff_err_o <= 1'b0;
        end else begin
            if (coeff_wr_i) begin
                if ({1'b0, coeff_addr_i} < (AW+1)'(NTAPS)) shadow[coeff_addr_i] <= coeff_dat_i;
                else coeff_err_o <= 1'b1;
            end
            if (ce_i && pend) active <= shadow;
            pend <= coeff_commit_i | (pend & ~ce_i);
        end
    end
    // pre-add, double-delay sample chain, product registers and systolic accumulate chain
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            xs    <= '{default: '0};
            a_d   <= '{default: '0};
            mr    <= '{default: '0};
            acc   <= '{default: '0};
            dat_o <= '0;
            sat_o <= 1'b0;
            pc_o  <= '0;
        end else if (ce_i) begin
            xs[0] <= XW'(dat_i) + XW'(preadd_i);
            for (int k = 1; k < NX; k++) xs[k] <= xs[k-1];
            a_d[0] <= add_i;
            a_d[1] <= a_d[0];
            for (int k = 0; k < NTAPS; k++) mr[k] <= 48'(active[k]) * 48'(xs[2*k]);
            acc[0] <= mr[0] + (48'(a_d[1]) <<< SCALE_ADD) + (CAS ? pc_i : 48'sd0);
            for (int k = 1; k < NTAPS; k++) acc[k] <= acc[k-1] + mr[k];
            pc_o  <= acc[NTAPS-1];
            dat_o <= y_c;
            sat_o <= sat_c;
        end
    end
    // round half to even after the shift, then clamp or wrap to the output width
    always_comb begin
        s     = acc[NTAPS-1];
        q     = s >>> OUT_SHIFT;
        frac  = s & MASK;
        up    = (OUT_SHIFT > 0) && ((frac > HALF) || (frac == HALF && q[0]));
        r     = q + 48'(up);
        hi    = r > MAXV;
        lo    = r < MINV;
        sat_c = SAT && (hi || lo);
        y_c   = !SAT ? r[XW-1:0] : hi ? MAXV[XW-1:0] : lo ? MINV[XW-1:0] : r[XW-1:0];
    end
    // state register advances only on ce
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= FILL;
            cnt   <= '0;
        end else if (ce_i) begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end
    // a pending commit always restarts a LAT-long blanking window; otherwise fill/flush count up to RUN
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        valid_o   = (state == RUN);
        if (pend) begin
            state_nxt = FLUSH;
            cnt_nxt   = '0;
        end else if (state != RUN) begin
            state_nxt = (cnt == CW'(LAT - 1)) ? RUN : state;
            cnt_nxt   = (cnt == CW'(LAT - 1)) ? '0 : cnt + CW'(1);
        end
    end
endmodule
